// File: rtl/prbs4_pkg.sv
// Shared types and constants for the 4-bit PRBS checker.
// Optional bit counter in the checker is enabled with PRBS4_CHK_BITCNT_EN.
package prbs4_pkg;

  typedef enum logic [1:0] {
    SEED,
    VERIFY,
    LOCKED
  } state_t;

  localparam int unsigned PRBS_W      = 4;
  localparam int unsigned TAP_A       = 0;
  localparam int unsigned TAP_B       = 1;
  localparam int unsigned PRBS_PERIOD = 15;

  // Feedback tap of the generator; also the checker's prediction of the next bit.
  function automatic logic prbs4_tap(input logic [PRBS_W-1:0] w);
    return w[TAP_A] ^ w[TAP_B];
  endfunction

endpackage

// File: rtl/prbs4_predict.sv
// Combinational next-bit predictor: window (w[0] oldest) -> expected incoming bit.
module prbs4_predict
  import prbs4_pkg::*;
(
  input  logic [PRBS_W-1:0] i_win,
  output logic              o_pred
);

  always_comb begin
    o_pred = prbs4_tap(i_win);
  end

endmodule

// File: rtl/prbs4_checker.sv
// Serial PRBS4 checker: self-synchronises, declares lock, flags and counts bit errors.
// Define PRBS4_CHK_BITCNT_EN to add the bit_cnt output (valid bits checked while locked).
module prbs4_checker
  import prbs4_pkg::*;
#(
  parameter int unsigned LOCK_GOOD  = 4,
  parameter int unsigned ERR_THRESH = 3,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
`ifdef PRBS4_CHK_BITCNT_EN
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] bit_cnt
`else
  output logic [CNT_W-1:0] err_cnt
`endif
);

  localparam int unsigned FILL_W = $clog2(PRBS_W + 1);
  localparam int unsigned GOOD_W = $clog2(LOCK_GOOD + 1);
  localparam int unsigned BAD_W  = $clog2(ERR_THRESH + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PRBS_W);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_GOOD - 1);
  localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(ERR_THRESH - 1);

  state_t              r_state;
  logic [PRBS_W-1:0]   r_win;
  logic [FILL_W-1:0]   r_fill;
  logic [GOOD_W-1:0]   r_good;
  logic [BAD_W-1:0]    r_bad;
  logic                r_locked;
  logic                r_err_pulse;
  logic [CNT_W-1:0]    r_err_cnt;

  logic                w_pred;
  logic                w_mismatch;
  logic [PRBS_W-1:0]   w_win_next;

  prbs4_predict u_predict (
    .i_win  (r_win),
    .o_pred (w_pred)
  );

  always_comb begin
    w_win_next = {din, r_win[PRBS_W-1:1]};
    w_mismatch = din ^ w_pred;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= SEED;
      r_win       <= '0;
      r_fill      <= '0;
      r_good      <= '0;
      r_bad       <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_err_pulse <= 1'b0;
      if (din_valid) begin
        r_win <= w_win_next;
        case (r_state)
          SEED: begin
            if (r_fill != FILL_FULL) begin
              r_fill <= r_fill + 1'b1;
            end
            // Judge the window including this bit, so the 4th bit already moves to VERIFY.
            if ((r_fill >= FILL_FULL - 1'b1) && (w_win_next != '0)) begin
              r_state <= VERIFY;
              r_good  <= '0;
            end
          end
          VERIFY: begin
            if (w_mismatch) begin
              r_state <= SEED;
              r_fill  <= '0;
            end else if (r_good == GOOD_LAST) begin
              r_state  <= LOCKED;
              r_locked <= 1'b1;
              r_bad    <= '0;
            end else begin
              r_good <= r_good + 1'b1;
            end
          end
          LOCKED: begin
            if (w_mismatch) begin
              r_err_pulse <= 1'b1;
              if (r_err_cnt != '1) begin
                r_err_cnt <= r_err_cnt + 1'b1;
              end
              if (r_bad == BAD_LAST) begin
                r_state  <= SEED;
                r_locked <= 1'b0;
                r_fill   <= '0;
              end else begin
                r_bad <= r_bad + 1'b1;
              end
            end else begin
              r_bad <= '0;
            end
          end
          default: begin
            r_state  <= SEED;
            r_locked <= 1'b0;
            r_fill   <= '0;
          end
        endcase
      end
      if (clr_cnt) begin
        r_err_cnt <= '0;
      end
    end
  end

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign err_cnt   = r_err_cnt;

`ifdef PRBS4_CHK_BITCNT_EN
  logic [CNT_W-1:0] r_bit_cnt;

  always_ff @(posedge clk) begin
    if (!rst || clr_cnt) begin
      r_bit_cnt <= '0;
    end else if (din_valid && (r_state == LOCKED) && (r_bit_cnt != '1)) begin
      r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

  assign bit_cnt = r_bit_cnt;
`endif

endmodule

// File: tb/tb_prbs4_checker.sv
// Self-checking bench for prbs4_checker: default instance plus a small-counter,
// high-threshold instance, both compared every cycle against a bit-history model.
module tb_prbs4_checker;
  import prbs4_pkg::*;

  localparam int M_HUNT = 0;
  localparam int M_VER  = 1;
  localparam int M_LOCK = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic din = 1'b0;
  logic din_valid = 1'b0;
  logic clr_cnt = 1'b0;

  logic        locked_a, err_pulse_a, locked_b, err_pulse_b;
  logic [15:0] err_cnt_a;
  logic [3:0]  err_cnt_b;

`ifdef PRBS4_CHK_BITCNT_EN
  logic [15:0] bit_cnt_a;
  logic [3:0]  bit_cnt_b;
  localparam int VW = 44;
  logic [VW-1:0] obs;
  assign obs = {locked_a, err_pulse_a, err_cnt_a, locked_b, err_pulse_b, err_cnt_b,
                bit_cnt_a, bit_cnt_b};
`else
  localparam int VW = 24;
  logic [VW-1:0] obs;
  assign obs = {locked_a, err_pulse_a, err_cnt_a, locked_b, err_pulse_b, err_cnt_b};
`endif

  prbs4_checker #(.LOCK_GOOD(4), .ERR_THRESH(3), .CNT_W(16)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .clr_cnt   (clr_cnt),
    .locked    (locked_a),
    .err_pulse (err_pulse_a),
`ifdef PRBS4_CHK_BITCNT_EN
    .err_cnt   (err_cnt_a),
    .bit_cnt   (bit_cnt_a)
`else
    .err_cnt   (err_cnt_a)
`endif
  );

  prbs4_checker #(.LOCK_GOOD(4), .ERR_THRESH(200), .CNT_W(4)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .clr_cnt   (clr_cnt),
    .locked    (locked_b),
    .err_pulse (err_pulse_b),
`ifdef PRBS4_CHK_BITCNT_EN
    .err_cnt   (err_cnt_b),
    .bit_cnt   (bit_cnt_b)
`else
    .err_cnt   (err_cnt_b)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference pattern and last four received bits (index 0 oldest).
  bit s[PRBS_PERIOD];
  int gpos = 0;
  bit hist[4] = '{0, 0, 0, 0};

  int m_mode[2], m_fill[2], m_good[2], m_bad[2], m_cnt[2], m_bits[2];
  bit m_pulse[2];
  int m_thr[2] = '{3, 200};
  int m_max[2] = '{65535, 15};

  function automatic bit pred_now();
    return hist[0] ^ hist[1];
  endfunction

  function automatic bit gen_bit();
    bit b;
    b = s[gpos];
    gpos = (gpos + 1) % PRBS_PERIOD;
    return b;
  endfunction

  function automatic logic [VW-1:0] exp_vec();
`ifdef PRBS4_CHK_BITCNT_EN
    return {m_mode[0] == M_LOCK, m_pulse[0], 16'(m_cnt[0]),
            m_mode[1] == M_LOCK, m_pulse[1], 4'(m_cnt[1]),
            16'(m_bits[0]), 4'(m_bits[1])};
`else
    return {m_mode[0] == M_LOCK, m_pulse[0], 16'(m_cnt[0]),
            m_mode[1] == M_LOCK, m_pulse[1], 4'(m_cnt[1])};
`endif
  endfunction

  task automatic model_step();
    bit mis, nz;
    mis = din ^ pred_now();
    nz  = din | hist[1] | hist[2] | hist[3];
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        m_mode[k] = M_HUNT; m_fill[k] = 0; m_good[k] = 0; m_bad[k] = 0;
        m_cnt[k] = 0; m_bits[k] = 0; m_pulse[k] = 0;
      end else begin
        m_pulse[k] = 0;
        if (din_valid) begin
          if (m_mode[k] == M_HUNT) begin
            if (m_fill[k] < 4) m_fill[k]++;
            if (m_fill[k] == 4 && nz) begin m_mode[k] = M_VER; m_good[k] = 0; end
          end else if (m_mode[k] == M_VER) begin
            if (mis) begin m_mode[k] = M_HUNT; m_fill[k] = 0; end
            else begin
              m_good[k]++;
              if (m_good[k] == 4) begin m_mode[k] = M_LOCK; m_bad[k] = 0; end
            end
          end else begin
            if (m_bits[k] < m_max[k]) m_bits[k]++;
            if (mis) begin
              m_pulse[k] = 1;
              if (m_cnt[k] < m_max[k]) m_cnt[k]++;
              m_bad[k]++;
              if (m_bad[k] == m_thr[k]) begin m_mode[k] = M_HUNT; m_fill[k] = 0; end
            end else m_bad[k] = 0;
          end
        end
        if (clr_cnt) begin m_cnt[k] = 0; m_bits[k] = 0; end
      end
    end
    if (!rst) hist = '{0, 0, 0, 0};
    else if (din_valid) hist = '{hist[1], hist[2], hist[3], din};
  endtask

  task automatic tick(input logic d, input logic v, input logic c);
    din = d; din_valid = v; clr_cnt = c;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (obs !== '0) begin
      n_fail++; $display("FAIL reset_state: got %h want 0", obs);
    end
    n_cmp++;
    if (obs !== exp_vec()) begin
      n_fail++; $display("FAIL reset_model: got %h want %h", obs, exp_vec());
    end
    rst = 1'b1;
  endtask

  task automatic test_lock_clean();
    int pulses = 0;
    gpos = 0;
    for (int i = 0; i < 100 * PRBS_PERIOD; i++) begin
      tick(gen_bit(), 1'b1, 1'b0);
      pulses += int'(err_pulse_a);
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL lock_clean bit %0d: got %h want %h", i, obs, exp_vec());
      end
      if (i == 6) begin
        n_cmp++;
        if (locked_a !== 1'b0) begin
          n_fail++; $display("FAIL lock_early: locked=%b want 0 after 7 bits", locked_a);
        end
      end
      if (i == 7) begin
        n_cmp++;
        if (locked_a !== 1'b1) begin
          n_fail++; $display("FAIL lock_point: locked=%b want 1 after 8 bits", locked_a);
        end
      end
    end
    n_cmp++;
    if (pulses != 0 || err_cnt_a !== 16'd0) begin
      n_fail++; $display("FAIL clean_errors: pulses=%0d cnt=%0d want 0/0", pulses, err_cnt_a);
    end
  endtask

  task automatic test_single_flip();
    int pulses = 0;
    int pre = int'(err_cnt_a);
    int at = $urandom_range(2, 16);
    for (int i = 0; i < 30; i++) begin
      bit b;
      b = gen_bit();
      tick(i == at ? ~b : b, 1'b1, 1'b0);
      pulses += int'(err_pulse_a);
      n_cmp++;
      if (obs !== exp_vec() || locked_a !== 1'b1) begin
        n_fail++; $display("FAIL single_flip bit %0d: got %h want %h", i, obs, exp_vec());
      end
    end
    n_cmp++;
    if (pulses != 3 || int'(err_cnt_a) - pre != 3) begin
      n_fail++;
      $display("FAIL flip_count: pulses=%0d delta=%0d want 3/3", pulses, int'(err_cnt_a) - pre);
    end
  endtask

  task automatic test_zero_loss();
    for (int i = 0; i < PRBS_PERIOD && gpos != 12; i++) tick(gen_bit(), 1'b1, 1'b0);
    for (int j = 0; j < 20; j++) begin
      tick(1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (obs !== exp_vec() || locked_a !== (j < 2)) begin
        n_fail++;
        $display("FAIL zero_loss zero %0d: locked=%b obs %h want %h", j, locked_a, obs, exp_vec());
      end
    end
  endtask

  task automatic test_valid_gaps();
    int nvalid = 0;
    int pulses = 0;
    rst = 1'b0;
    tick(1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    gpos = $urandom_range(0, PRBS_PERIOD - 1);
    for (int c = 0; c < 200; c++) begin
      bit v, b;
      v = 1'($urandom_range(0, 1));
      b = v ? gen_bit() : 1'($urandom_range(0, 1));
      tick(b, v, 1'b0);
      if (v) nvalid++;
      pulses += int'(err_pulse_a);
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL valid_gaps cyc %0d: got %h want %h", c, obs, exp_vec());
      end
      if (v && (nvalid == 7 || nvalid == 8)) begin
        n_cmp++;
        if (locked_a !== (nvalid == 8)) begin
          n_fail++; $display("FAIL gap_lock: locked=%b at valid bit %0d", locked_a, nvalid);
        end
      end
    end
    n_cmp++;
    if (nvalid < 8 || pulses != 0 || err_cnt_a !== 16'd0) begin
      n_fail++;
      $display("FAIL gap_errors: nvalid=%0d pulses=%0d cnt=%0d", nvalid, pulses, err_cnt_a);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 40; i++) begin
      tick(~pred_now(), 1'b1, 1'b0);
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL saturate bit %0d: got %h want %h", i, obs, exp_vec());
      end
    end
    n_cmp++;
    if (err_cnt_b !== 4'hF || locked_b !== 1'b1) begin
      n_fail++; $display("FAIL sat_hold: cnt=%h locked=%b want f/1", err_cnt_b, locked_b);
    end
    tick(~pred_now(), 1'b1, 1'b1);
    n_cmp++;
    if (err_cnt_b !== 4'h0 || err_pulse_b !== 1'b1 || obs !== exp_vec()) begin
      n_fail++; $display("FAIL clr_wins: cnt=%h pulse=%b want 0/1", err_cnt_b, err_pulse_b);
    end
    clr_cnt = 1'b0;
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 40; i++) begin
      tick(gen_bit(), 1'b1, 1'b0);
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL relock_pre bit %0d: got %h want %h", i, obs, exp_vec());
      end
    end
    tick(~gen_bit(), 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) tick(gen_bit(), 1'b1, 1'b0);
    n_cmp++;
    if (locked_a !== 1'b1 || err_cnt_a !== 16'd3) begin
      n_fail++; $display("FAIL pre_reset: locked=%b cnt=%0d want 1/3", locked_a, err_cnt_a);
    end
    rst = 1'b0;
    tick(gen_bit(), 1'b1, 1'b0);
    rst = 1'b1;
    n_cmp++;
    if (locked_a !== 1'b0 || err_cnt_a !== 16'd0 || obs !== exp_vec()) begin
      n_fail++; $display("FAIL mid_reset: locked=%b cnt=%0d want 0/0", locked_a, err_cnt_a);
    end
    for (int i = 0; i < 8; i++) begin
      tick(gen_bit(), 1'b1, 1'b0);
      n_cmp++;
      if (obs !== exp_vec() || locked_a !== (i == 7)) begin
        n_fail++; $display("FAIL relock bit %0d: locked=%b obs %h want %h", i, locked_a, obs, exp_vec());
      end
    end
  endtask

  initial begin
    logic [PRBS_W-1:0] q;
    q = 4'b1000;
    for (int i = 0; i < PRBS_PERIOD; i++) begin
      s[i] = q[0];
      q = {q[0] ^ q[1], q[3:1]};
    end
    test_reset();
    test_lock_clean();
    test_single_flip();
    test_zero_loss();
    test_valid_gaps();
    test_saturation();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
